dm_lane_ram_clr: RTL and testbench
==================================

# dm_lane_ram_clr

Parametrised single-port data memory for the AVR core, the successor to the plain single-port data RAM. It adds per-lane byte write enables, a registered read port with an explicit valid strobe, and a selectable read-during-write policy. A hardware clear engine sweeps the whole array to a constant after reset or on request. It sits between the CPU data bus and the FPGA BRAM, one instance per data space.

## Interface
- `LANE_W`, 8: bits per byte lane.
- `LANES`, 1: number of lanes. Data width is `DW = LANES*LANE_W`.
- `ADDR_W`, 12: address width. Depth is `2**ADDR_W` words.
- `RDW_MODE`, 0: read-during-write policy. 0 = read-old, 1 = write-first.
- `CLEAR_ON_RESET`, 1: 1 = run a clear sweep after every reset release.
- `CLEAR_VALUE`, 0: `LANE_W`-bit pattern written to every lane during a clear.

- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `clr_i`  in  1  clear request, sampled while idle.
- `busy_o`  out  1  clear in progress; accesses ignored.
- `we_i`  in  LANES  per-lane write enable.
- `re_i`  in  1  read request.
- `addr_i`  in  ADDR_W  word address.
- `d_i`  in  DW  write data; lane k is bits `[k*LANE_W +: LANE_W]`.
- `d_o`  out  DW  registered read data.
- `valid_o`  out  1  `d_o` updated this cycle.

## Operation
- The FSM has three states: RST_WAIT, CLEAR and IDLE.
  - RST_WAIT is the state entered on reset. On the first clock after release it moves to CLEAR if `CLEAR_ON_RESET`=1, otherwise to IDLE.
  - CLEAR: the address counter `cnt` starts at 0. Each cycle, all lanes at `cnt` are written with `CLEAR_VALUE` and `cnt` increments. After `cnt`=`2**ADDR_W-1` is written, the FSM goes to IDLE and `cnt` wraps to 0.
  - IDLE to CLEAR happens when `clr_i`=1 at a rising edge.
- `busy_o` = 1 in RST_WAIT when `CLEAR_ON_RESET`=1, and in CLEAR. It is 0 otherwise.
- While `busy_o`=1, `we_i` and `re_i` are ignored: no write, `valid_o`=0, `d_o` holds.
- `clr_i` asserted during CLEAR is ignored; the sweep does not restart.
- In IDLE, `clr_i` has priority over a same-cycle access. That access is dropped.
- Write in IDLE: for each k with `we_i[k]`=1, lane k at `addr_i` takes lane k of `d_i`. Other lanes are unchanged.
- Read in IDLE: `re_i`=1 at edge N gives `d_o` = word at `addr_i` after edge N, and `valid_o`=1 for exactly that cycle.
- Without `re_i`, `d_o` holds its last value and `valid_o`=0.
- Read and write to the same address in the same cycle:
  - `RDW_MODE`=0: `d_o` returns the pre-write word.
  - `RDW_MODE`=1: written lanes return the new `d_i` lanes; unwritten lanes return the old contents.
- Memory contents are not affected by `rst_i`. Only a clear sweep initialises them.

## Timing
- Reset values: FSM = RST_WAIT, `cnt`=0, `d_o`=0, `valid_o`=0, `busy_o`=`CLEAR_ON_RESET`.
- Read latency is 1 cycle. Throughput is one access per cycle with no bubbles.
- Clear duration is exactly `2**ADDR_W` cycles in CLEAR. `busy_o` falls on the edge that writes the last address.
  - After reset: RST_WAIT (1 cycle), then CLEAR for `2**ADDR_W` cycles, so `busy_o` lasts `2**ADDR_W+1` cycles after release.
  - On request: `clr_i` at edge N, then CLEAR for `2**ADDR_W` cycles, then IDLE. Accesses are accepted again at the first edge after `busy_o` falls.
- Reset mid-sweep: the sweep aborts immediately (async) and `d_o`/`valid_o` clear.
  - With `CLEAR_ON_RESET`=1, a full sweep restarts from address 0 after release.
  - With `CLEAR_ON_RESET`=0, memory is left partly cleared. This is acceptable and documented.
- `d_o` comes directly from a register, with no combinational path from the inputs.

## Structure
- Shared header `avr_mem_defs.vh` holds the FSM state encodings (`ST_RST_WAIT`, `ST_CLEAR`, `ST_IDLE`) and the `RDW_READ_OLD`/`RDW_WRITE_FIRST` constants.
- Sub-module `dm_lane_bram`: one `LANE_W`×`2**ADDR_W` synchronous-write BRAM inference template, instantiated `LANES` times via generate.
  - The top level muxes address and data between the clear engine and the CPU port.
  - The top level also implements the write-first bypass for `RDW_MODE`=1.

## Test plan
- Reset, default params, `ADDR_W`=4: `busy_o`=1 for 17 cycles after release. Then reads of addresses 0..15 each return 0x00 with `valid_o` pulsed one cycle after `re_i`.
- `LANES`=2: write 0xA55A to address 3, then write `we_i`=2'b01 with 0x00FF → reading address 3 returns 0xA5FF.
- Same-cycle read+write to address 5 (old 0x1234, new 0xBEEF, `we_i`=11):
  - `RDW_MODE`=0 gives `d_o`=0x1234.
  - `RDW_MODE`=1 gives 0xBEEF.
  - A second read gives 0xBEEF in both modes.
- `clr_i` with a simultaneous write of 0x77 to address 2, `CLEAR_VALUE`=0xCC:
  - The write is dropped and `busy_o` is high for 16 cycles.
  - `re_i` pulses during busy give `valid_o`=0.
  - Afterwards, all addresses read 0xCC.
- Assert `rst_i` while `cnt`=7 mid-sweep: `busy_o` stays 1 (`CLEAR_ON_RESET`=1), then a full 16-cycle sweep follows. With `CLEAR_ON_RESET`=0, `busy_o`=0 right after release.
- `clr_i` re-asserted at sweep cycle 10: the sweep still ends at cycle 16 and does not restart.

Source files
------------

// File: rtl/dm_lane_ram_clr_pkg.sv
// Shared definitions for the lane-enabled data RAM with clear engine.
package dm_lane_ram_clr_pkg;

  typedef enum logic [1:0] {
    StRstWait = 2'd0,
    StClear   = 2'd1,
    StIdle    = 2'd2
  } state_e;

  localparam int unsigned RdwReadOld    = 0;
  localparam int unsigned RdwWriteFirst = 1;

endpackage

// File: rtl/dm_lane_ram_clr_bram.sv
// One byte lane of storage: synchronous write, registered read-old output.
module dm_lane_ram_clr_bram #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LANE_W-1:0] d_i,
  output logic [LANE_W-1:0] q_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [LANE_W-1:0] r_mem [Depth];
  logic [LANE_W-1:0] r_q;

  // Contents deliberately have no reset; only the clear sweep initialises them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else if (re_i) begin
      r_q <= r_mem[addr_i];
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/dm_lane_ram_clr.sv
// Single-port data RAM with per-lane write enables, registered read, selectable
// read-during-write policy and a hardware clear sweep.
module dm_lane_ram_clr
  import dm_lane_ram_clr_pkg::*;
#(
  parameter int unsigned      LANE_W         = 8,
  parameter int unsigned      LANES          = 1,
  parameter int unsigned      ADDR_W         = 12,
  parameter int unsigned      RDW_MODE       = 0,
  parameter int unsigned      CLEAR_ON_RESET = 1,
  parameter logic [LANE_W-1:0] CLEAR_VALUE   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  output logic                     busy_o,
  input  logic [LANES-1:0]         we_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [LANES*LANE_W-1:0]  d_i,
  output logic [LANES*LANE_W-1:0]  d_o,
  output logic                     valid_o
);

  localparam int unsigned       DW       = LANES * LANE_W;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;

  logic              w_busy;
  logic              w_clear_wr;
  logic              w_cpu_en;
  logic              w_rd;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [LANES-1:0]  w_byp_we;
  logic [DW-1:0]     w_ram_q;

  logic              r_valid;
  logic [LANES-1:0]  r_byp_sel;
  logic [DW-1:0]     r_byp_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StRstWait;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StRstWait: w_state_nxt = (CLEAR_ON_RESET != 0) ? StClear : StIdle;
      StClear:   if (r_cnt == LastAddr) w_state_nxt = StIdle;
      StIdle:    if (clr_i) w_state_nxt = StClear;
      default:   w_state_nxt = StRstWait;
    endcase
  end

  // A clear request in IDLE wins over any same-cycle CPU access.
  always_comb begin
    w_busy     = 1'b0;
    w_clear_wr = 1'b0;
    w_cpu_en   = 1'b0;
    unique case (r_state)
      StRstWait: w_busy = (CLEAR_ON_RESET != 0);
      StClear: begin
        w_busy     = 1'b1;
        w_clear_wr = 1'b1;
      end
      StIdle:    w_cpu_en = ~clr_i;
      default: ;
    endcase
  end

  // Counter wraps to zero on the last sweep write, ready for the next request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (r_state == StClear) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  assign busy_o     = w_busy;
  assign w_rd       = w_cpu_en & re_i;
  assign w_mem_addr = w_clear_wr ? r_cnt : addr_i;
  assign w_byp_we   = (RDW_MODE == RdwWriteFirst) ? (we_i & {LANES{w_cpu_en}}) : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic              w_we;
    logic [LANE_W-1:0] w_d;

    assign w_we = w_clear_wr | (w_cpu_en & we_i[k]);
    assign w_d  = w_clear_wr ? CLEAR_VALUE : d_i[k*LANE_W +: LANE_W];

    dm_lane_ram_clr_bram #(
      .LANE_W (LANE_W),
      .ADDR_W (ADDR_W)
    ) u_bram (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .we_i   (w_we),
      .re_i   (w_rd),
      .addr_i (w_mem_addr),
      .d_i    (w_d),
      .q_o    (w_ram_q[k*LANE_W +: LANE_W])
    );

    // Write-first lanes come from the captured write data, never from live inputs.
    assign d_o[k*LANE_W +: LANE_W] = r_byp_sel[k] ? r_byp_d[k*LANE_W +: LANE_W]
                                                  : w_ram_q[k*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_byp_sel <= '0;
      r_byp_d   <= '0;
    end else begin
      r_valid <= w_rd;
      if (w_rd) begin
        r_byp_sel <= w_byp_we;
        r_byp_d   <= d_i;
      end
    end
  end

  assign valid_o = r_valid;

endmodule

// File: tb/tb_dm_lane_ram_clr.sv
// Bench: DUT A is read-old with clear-on-reset, DUT B is write-first without it.
module tb_dm_lane_ram_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_clr, a_re, a_busy, a_valid;
  logic [1:0]  a_we;
  logic [3:0]  a_addr;
  logic [15:0] a_d, a_q;
  logic        b_clr, b_re, b_busy, b_valid;
  logic [1:0]  b_we;
  logic [3:0]  b_addr;
  logic [15:0] b_d, b_q;

  int          total = 0;
  int          bad = 0;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] ma[16];
  logic [15:0] mb[16];
  bit          a_pv, b_pv;
  logic [15:0] ea, eb;
  int          n;

  dm_lane_ram_clr #(
    .LANE_W(8), .LANES(2), .ADDR_W(4), .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(a_clr), .busy_o(a_busy), .we_i(a_we), .re_i(a_re),
    .addr_i(a_addr), .d_i(a_d), .d_o(a_q), .valid_o(a_valid)
  );

  dm_lane_ram_clr #(
    .LANE_W(8), .LANES(2), .ADDR_W(4), .RDW_MODE(1), .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'hCC)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(b_clr), .busy_o(b_busy), .we_i(b_we), .re_i(b_re),
    .addr_i(b_addr), .d_i(b_d), .d_o(b_q), .valid_o(b_valid)
  );

  // Scoreboard: pop one expected word per valid strobe.
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL rd_a: valid with no read pending, d_o=%h", a_q);
      end else begin
        ea = qa.pop_front();
        if (a_q !== ea) begin
          bad++;
          $display("FAIL rd_a: got %h want %h", a_q, ea);
        end
      end
    end
    if (b_valid === 1'b1) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL rd_b: valid with no read pending, d_o=%h", b_q);
      end else begin
        eb = qb.pop_front();
        if (b_q !== eb) begin
          bad++;
          $display("FAIL rd_b: got %h want %h", b_q, eb);
        end
      end
    end
  end

  // s: 0 = DUT A, 1 = DUT B, 2 = both. acc: bench expects the access to be accepted.
  task automatic drive(input int s, input logic clr, input logic [1:0] we, input logic re,
                       input logic [3:0] addr, input logic [15:0] d, input bit acc);
    logic [15:0] old, mrg;
    total++;
    if (a_valid !== a_pv) begin
      bad++;
      $display("FAIL valid_a: got %b want %b", a_valid, a_pv);
    end
    total++;
    if (b_valid !== b_pv) begin
      bad++;
      $display("FAIL valid_b: got %b want %b", b_valid, b_pv);
    end
    a_pv = 1'b0; b_pv = 1'b0;
    a_clr = 1'b0; a_we = 2'b00; a_re = 1'b0; a_addr = 4'h0; a_d = 16'h0;
    b_clr = 1'b0; b_we = 2'b00; b_re = 1'b0; b_addr = 4'h0; b_d = 16'h0;
    if (s == 0 || s == 2) begin
      a_clr = clr; a_we = we; a_re = re; a_addr = addr; a_d = d;
      if (acc && !clr) begin
        old = ma[addr];
        mrg = {we[1] ? d[15:8] : old[15:8], we[0] ? d[7:0] : old[7:0]};
        if (re) begin
          qa.push_back(old);
          a_pv = 1'b1;
        end
        ma[addr] = mrg;
      end
    end
    if (s == 1 || s == 2) begin
      b_clr = clr; b_we = we; b_re = re; b_addr = addr; b_d = d;
      if (acc && !clr) begin
        old = mb[addr];
        mrg = {we[1] ? d[15:8] : old[15:8], we[0] ? d[7:0] : old[7:0]};
        if (re) begin
          qb.push_back(mrg);
          b_pv = 1'b1;
        end
        mb[addr] = mrg;
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      drive(2, 1'b0, 2'b00, 1'b0, 4'h0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_reset();
    total++;
    if (a_busy !== 1'b1 || a_valid !== 1'b0 || a_q !== 16'h0) begin
      bad++;
      $display("FAIL reset_a: busy=%b valid=%b d_o=%h want 1 0 0000", a_busy, a_valid, a_q);
    end
    total++;
    if (b_busy !== 1'b0 || b_valid !== 1'b0 || b_q !== 16'h0) begin
      bad++;
      $display("FAIL reset_b: busy=%b valid=%b d_o=%h want 0 0 0000", b_busy, b_valid, b_q);
    end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_busy !== 1'b1) break;
      n++;
      @(negedge clk);
      drive(2, 1'b0, 2'b00, 1'b0, 4'h0, 16'h0, 1'b0);
    end
    total++;
    if (n != 17) begin
      bad++;
      $display("FAIL busy_after_reset: got %0d cycles want 17", n);
    end
    total++;
    if (b_busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_b_no_clear: got %b want 0", b_busy);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 2'b00, 1'b1, 4'(i), 16'h0, 1'b1);
    end
    idle(2);
  endtask

  task automatic test_lanes();
    @(negedge clk); drive(0, 1'b0, 2'b11, 1'b0, 4'd3, 16'hA55A, 1'b1);
    @(negedge clk); drive(0, 1'b0, 2'b01, 1'b0, 4'd3, 16'h00FF, 1'b1);
    @(negedge clk); drive(0, 1'b0, 2'b00, 1'b1, 4'd3, 16'h0000, 1'b1);
    idle(2);
    total++;
    if (a_q !== 16'hA5FF) begin
      bad++;
      $display("FAIL lane_we_hold: got %h want a5ff", a_q);
    end
  endtask

  task automatic test_rdw(input int s);
    @(negedge clk); drive(s, 1'b0, 2'b11, 1'b0, 4'd5, 16'h1234, 1'b1);
    @(negedge clk); drive(s, 1'b0, 2'b11, 1'b1, 4'd5, 16'hBEEF, 1'b1);
    @(negedge clk); drive(s, 1'b0, 2'b00, 1'b1, 4'd5, 16'h0000, 1'b1);
    @(negedge clk); drive(s, 1'b0, 2'b01, 1'b1, 4'd5, 16'h5678, 1'b1);
    idle(2);
    if (s == 0) begin
      total++;
      if (a_q !== 16'hBEEF) begin
        bad++;
        $display("FAIL rdw_old_partial: got %h want beef", a_q);
      end
    end else begin
      total++;
      if (b_q !== 16'hBE78) begin
        bad++;
        $display("FAIL rdw_first_partial: got %h want be78", b_q);
      end
    end
  endtask

  task automatic test_clear_req();
    @(negedge clk); drive(1, 1'b1, 2'b11, 1'b0, 4'd2, 16'h0077, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_busy !== 1'b1) begin
        drive(2, 1'b0, 2'b00, 1'b0, 4'h0, 16'h0, 1'b1);
        break;
      end
      n++;
      drive(1, 1'b0, 2'b00, 1'b1, 4'(i), 16'h0, 1'b0);
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL busy_clear_req: got %0d cycles want 16", n);
    end
    for (int i = 0; i < 16; i++) mb[i] = 16'hCCCC;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(1, 1'b0, 2'b00, 1'b1, 4'(i), 16'h0, 1'b1);
    end
    idle(2);
  endtask

  task automatic test_clr_reassert();
    @(negedge clk); drive(0, 1'b0, 2'b11, 1'b0, 4'd9, 16'h3C3C, 1'b1);
    @(negedge clk); drive(0, 1'b1, 2'b00, 1'b0, 4'd0, 16'h0, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_busy !== 1'b1) begin
        drive(2, 1'b0, 2'b00, 1'b0, 4'h0, 16'h0, 1'b1);
        break;
      end
      n++;
      drive(0, (i == 9), 2'b00, 1'b0, 4'h0, 16'h0, 1'b0);
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clr_reassert: got %0d busy cycles want 16", n);
    end
    for (int i = 0; i < 16; i++) ma[i] = 16'h0;
    @(negedge clk); drive(0, 1'b0, 2'b00, 1'b1, 4'd9, 16'h0, 1'b1);
    idle(3);
    total++;
    if (a_busy !== 1'b0) begin
      bad++;
      $display("FAIL no_restart: busy got %b want 0", a_busy);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(0, 1'b0, 2'b11, 1'b0, 4'(i), 16'($urandom), 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive(0, 1'b0, 2'b00, 1'b1, 4'(i), 16'h0, 1'b1);
    end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(0, 1'b0, 2'($urandom), 1'b1, 4'($urandom_range(0, 7)), 16'($urandom), 1'b1);
    end
    idle(2);
  endtask

  task automatic test_rst_mid_sweep();
    @(negedge clk); drive(0, 1'b0, 2'b11, 1'b1, 4'd1, 16'h5A5A, 1'b1);
    @(negedge clk); drive(0, 1'b0, 2'b00, 1'b1, 4'd1, 16'h0, 1'b1);
    idle(1);
    @(negedge clk); drive(2, 1'b1, 2'b00, 1'b0, 4'h0, 16'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); drive(2, 1'b0, 2'b00, 1'b0, 4'h0, 16'h0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    a_pv = 1'b0; b_pv = 1'b0;
    #1;
    total++;
    if (a_busy !== 1'b1 || a_valid !== 1'b0 || a_q !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid_a: busy=%b valid=%b d_o=%h want 1 0 0000", a_busy, a_valid, a_q);
    end
    total++;
    if (b_busy !== 1'b0 || b_q !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid_b: busy=%b d_o=%h want 0 0000", b_busy, b_q);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (a_busy !== 1'b1) break;
      n++;
      @(negedge clk);
      drive(2, 1'b0, 2'b00, 1'b0, 4'h0, 16'h0, 1'b0);
      if (i == 0) begin
        total++;
        if (b_busy !== 1'b0) begin
          bad++;
          $display("FAIL rst_mid_b_release: busy got %b want 0", b_busy);
        end
      end
    end
    total++;
    if (n != 17) begin
      bad++;
      $display("FAIL rst_mid_resweep: got %0d busy cycles want 17", n);
    end
    for (int i = 0; i < 16; i++) ma[i] = 16'h0;
    for (int i = 0; i < 7; i++) mb[i] = 16'hCCCC;
    @(negedge clk); drive(0, 1'b0, 2'b00, 1'b1, 4'd1, 16'h0, 1'b1);
    @(negedge clk); drive(2, 1'b0, 2'b00, 1'b1, 4'd3, 16'h0, 1'b1);
    @(negedge clk); drive(0, 1'b0, 2'b00, 1'b1, 4'd12, 16'h0, 1'b1);
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    a_clr = 1'b0; a_we = 2'b00; a_re = 1'b0; a_addr = 4'h0; a_d = 16'h0;
    b_clr = 1'b0; b_we = 2'b00; b_re = 1'b0; b_addr = 4'h0; b_d = 16'h0;
    a_pv = 1'b0; b_pv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ma[i] = 16'h0;
      mb[i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_lanes();
    test_rdw(0);
    test_clear_req();
    test_rdw(1);
    test_clr_reassert();
    test_back_to_back();
    test_rst_mid_sweep();
    idle(3);
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL pending_reads: a=%0d b=%0d want 0 0", qa.size(), qb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
